i2c_target: RTL and testbench
=============================

Name: i2c_target

Overview:
- I2C target (responder) for the FMC424 I2C bus: the far end of the controller whose SCL the clock generator produces.
- Samples SCL/SDA, detects START/STOP, matches a 7-bit address and ACKs it.
- On a write, delivers received bytes to fabric. On a read, shifts fabric-supplied bytes onto SDA.
- Runs on the 156.25 MHz fabric clock; SDA is driven through an open-drain tristate enable.

Parameters:
- TARGET_ADDR, 7'h50, 7-bit address this target responds to.
- FILT_CYC, 4, consecutive stable CLK cycles needed before a filtered SCL/SDA level changes (range 1..15).
- HOLD_CYC, 8, CLK cycles after a filtered SCL falling edge before sda_t changes (range 1..63, about 51 ns at default).

Ports:
- CLK  in  1  156.25 MHz fabric clock.
- RST  in  1  synchronous reset, active high.
- scl_i  in  1  raw SCL pad input.
- sda_i  in  1  raw SDA pad input.
- sda_t  out  1  SDA tristate enable: 1 = released (high-Z), 0 = drive low.
- rx_data  out  8  last received write byte, MSB first on the wire.
- rx_valid  out  1  one-cycle pulse: new rx_data.
- tx_data  in  8  byte to send on a read; must be stable whenever tx_ack may pulse.
- tx_ack  out  1  one-cycle pulse: tx_data captured into the shift register.
- busy  out  1  high from an address match until STOP or abort.

Behaviour:
- Reset values: sda_t=1, rx_data=8'h00, rx_valid=0, tx_ack=0, busy=0, state IDLE. Filter outputs reset to 1; bit counter resets to 0.
- Input path:
  - 2-flop synchronizer per input, then the stability filter.
  - Filtered level takes the synced value only after FILT_CYC identical consecutive samples.
  - Edge flags (scl_rise, scl_fall, sda_rise, sda_fall) are 1-cycle pulses from the filtered signals.
- START = sda_fall while filtered SCL=1. STOP = sda_rise while filtered SCL=1.
  - Both are recognised in every state and take priority over data handling in the same cycle.
- Sampling and drive timing:
  - Data is sampled on scl_rise.
  - Every sda_t change is scheduled by scl_fall and applied exactly HOLD_CYC cycles later via a hold counter.
  - A new scl_fall restarts the hold counter.
- States:
  - IDLE: sda_t=1, busy=0. START -> ADDR with bit counter cleared.
  - ADDR: shift 8 bits on scl_rise (7 address bits, then R/W).
    - 8th bit with address == TARGET_ADDR -> ADDR_ACK, busy=1.
    - Mismatch -> IDLE; no ACK, ignore the bus until the next START.
  - ADDR_ACK: next scl_fall (+HOLD) sets sda_t=0.
    - Following scl_fall: if R/W=0, release sda_t (+HOLD) -> WR_DATA.
    - If R/W=1, load tx_data, pulse tx_ack in the cycle of that scl_fall, drive bit 7 (+HOLD) -> RD_DATA.
  - WR_DATA: shift 8 bits on scl_rise.
    - After the 8th, rx_data updates and rx_valid pulses in the next cycle -> WR_ACK.
  - WR_ACK: same drive/release timing as ADDR_ACK -> WR_DATA. Every byte is ACKed.
  - RD_DATA: drive each bit on scl_fall (+HOLD), sda_t = bit value (1 = release).
    - After 8 bits, the next scl_fall releases sda_t -> RD_ACK.
  - RD_ACK: sample SDA on scl_rise.
    - 0 (ACK): on the next scl_fall load tx_data, pulse tx_ack, drive bit 7 -> RD_DATA.
    - 1 (NACK): -> IDLE, sda_t stays 1.
- STOP in any state: sda_t=1 within 1 cycle of detection, busy=0, pending hold action cancelled -> IDLE. A byte interrupted by STOP produces no rx_valid.
- Repeated START in any state: release SDA, clear bit counter -> ADDR, busy=0 until the next match.
- Bit counter: 3-bit; wraps 7->0 only on entry to ACK states.
- RST mid-transfer: all outputs return to reset values the next cycle; bus traffic is ignored until a fresh START.

Test Plan:
- Write 0x50/W, data 0xA5, 0x3C, STOP -> ACK low on the 9th clock of all three bytes; rx_valid pulses twice with rx_data 0xA5 then 0x3C; busy falls after STOP.
- Address 0x51/W -> no ACK (sda_t stays 1 throughout), no rx_valid, busy stays 0.
- Read 0x50/R, tx_data=0xC3, master ACK, tx_data=0x5A, master NACK, STOP -> SDA carries 11000011 then 01011010; tx_ack pulses twice; sda_t=1 after the NACK.
- Write 0x50/W, 4 bits of data, repeated START, 0x50/R -> no rx_valid; second address ACKed; read proceeds.
- 2-cycle glitch on SCL during a data bit with FILT_CYC=4 -> no extra bit shifted; received byte is correct.
- RST asserted mid-read while sda_t=0 -> sda_t=1 the next cycle; subsequent bits ignored until a new START.

Source files
------------

// File: rtl/i2c_target.sv
// ============================================================================
// Module  : i2c_target
// Purpose : I2C target with filtered SCL/SDA, 7-bit address match, byte
//           write delivery and byte read shifting over open-drain SDA.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module i2c_target #(
  parameter logic [6:0] TARGET_ADDR = 7'h50,
  parameter int         FILT_CYC    = 4,
  parameter int         HOLD_CYC    = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_t,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ack,
  output logic       busy
);

  localparam logic [3:0] FILT_LAST = 4'(FILT_CYC - 1);
  localparam logic [5:0] HOLD_LD   = 6'(HOLD_CYC - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ADDR     = 3'd1,
    ADDR_ACK = 3'd2,
    WR_DATA  = 3'd3,
    WR_ACK   = 3'd4,
    RD_DATA  = 3'd5,
    RD_ACK   = 3'd6
  } state_t;

  // Index 0 carries SCL, index 1 carries SDA through the input path.
  logic [1:0]      raw, sync1, sync2, filt, filt_d;
  logic [1:0][3:0] fcnt;

  logic scl_f, sda_f;
  logic scl_rise, scl_fall, sda_rise, sda_fall;
  logic start, stop;

  state_t     state, state_n;
  logic [2:0] bitcnt;
  logic [6:0] shreg;
  logic [6:0] tx_sr;
  logic       rw;
  logic       acked;
  logic       pend, pend_val;
  logic [5:0] hold_cnt;

  logic bit_clr, bit_inc, shift_in, rw_load, ack_set, ack_clr;
  logic load_tx, shift_tx, rx_store, release_now, sched, sched_val;

  assign raw = {sda_i, scl_i};

  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1  <= 2'b11;
      sync2  <= 2'b11;
      filt   <= 2'b11;
      filt_d <= 2'b11;
      fcnt   <= '0;
    end else begin
      sync1  <= raw;
      sync2  <= sync1;
      filt_d <= filt;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == filt[i]) begin
          fcnt[i] <= 4'd0;
        end else if (fcnt[i] == FILT_LAST) begin
          filt[i] <= sync2[i];
          fcnt[i] <= 4'd0;
        end else begin
          fcnt[i] <= fcnt[i] + 4'd1;
        end
      end
    end
  end

  assign scl_f    = filt[0];
  assign sda_f    = filt[1];
  assign scl_rise =  filt[0] & ~filt_d[0];
  assign scl_fall = ~filt[0] &  filt_d[0];
  assign sda_rise =  filt[1] & ~filt_d[1];
  assign sda_fall = ~filt[1] &  filt_d[1];
  // Filtered SCL is the post-edge level, so simultaneous SCL/SDA drops are not a START.
  assign start    = sda_fall & scl_f;
  assign stop     = sda_rise & scl_f;

  assign busy   = (state != IDLE) && (state != ADDR);
  assign tx_ack = load_tx;

  always_comb begin
    state_n     = state;
    bit_clr     = 1'b0;
    bit_inc     = 1'b0;
    shift_in    = 1'b0;
    rw_load     = 1'b0;
    ack_set     = 1'b0;
    ack_clr     = 1'b0;
    load_tx     = 1'b0;
    shift_tx    = 1'b0;
    rx_store    = 1'b0;
    release_now = 1'b0;
    sched       = 1'b0;
    sched_val   = 1'b1;
    if (stop) begin
      state_n     = IDLE;
      release_now = 1'b1;
    end else if (start) begin
      state_n     = ADDR;
      bit_clr     = 1'b1;
      release_now = 1'b1;
    end else begin
      case (state)
        ADDR: if (scl_rise) begin
          shift_in = 1'b1;
          if (bitcnt != 3'd7) begin
            bit_inc = 1'b1;
          end else if (shreg == TARGET_ADDR) begin
            bit_inc = 1'b1;
            rw_load = 1'b1;
            ack_clr = 1'b1;
            state_n = ADDR_ACK;
          end else begin
            state_n = IDLE;
          end
        end
        ADDR_ACK, WR_ACK: if (scl_fall) begin
          sched = 1'b1;
          if (!acked) begin
            sched_val = 1'b0;
            ack_set   = 1'b1;
          end else if (state == WR_ACK || !rw) begin
            state_n = WR_DATA;
          end else begin
            sched_val = tx_data[7];
            load_tx   = 1'b1;
            state_n   = RD_DATA;
          end
        end
        WR_DATA: if (scl_rise) begin
          shift_in = 1'b1;
          bit_inc  = 1'b1;
          if (bitcnt == 3'd7) begin
            rx_store = 1'b1;
            ack_clr  = 1'b1;
            state_n  = WR_ACK;
          end
        end
        RD_DATA: if (scl_fall) begin
          sched   = 1'b1;
          bit_inc = 1'b1;
          if (bitcnt == 3'd7) begin
            ack_clr = 1'b1;
            state_n = RD_ACK;
          end else begin
            shift_tx  = 1'b1;
            sched_val = tx_sr[6];
          end
        end
        RD_ACK: begin
          if (scl_rise) begin
            if (sda_f) state_n = IDLE;
            else       ack_set = 1'b1;
          end else if (scl_fall && acked) begin
            sched     = 1'b1;
            sched_val = tx_data[7];
            load_tx   = 1'b1;
            state_n   = RD_DATA;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      bitcnt   <= 3'd0;
      shreg    <= 7'd0;
      tx_sr    <= 7'd0;
      rw       <= 1'b0;
      acked    <= 1'b0;
      rx_data  <= 8'h00;
      rx_valid <= 1'b0;
      sda_t    <= 1'b1;
      pend     <= 1'b0;
      pend_val <= 1'b1;
      hold_cnt <= 6'd0;
    end else begin
      state    <= state_n;
      rx_valid <= rx_store;
      if (bit_clr)      bitcnt <= 3'd0;
      else if (bit_inc) bitcnt <= bitcnt + 3'd1;
      if (shift_in) shreg <= {shreg[5:0], sda_f};
      if (rw_load)  rw    <= sda_f;
      if (ack_clr)      acked <= 1'b0;
      else if (ack_set) acked <= 1'b1;
      if (load_tx)       tx_sr <= tx_data[6:0];
      else if (shift_tx) tx_sr <= {tx_sr[5:0], 1'b0};
      if (rx_store) rx_data <= {shreg, sda_f};
      // Each scheduled level lands exactly HOLD_CYC cycles after its SCL fall.
      if (release_now) begin
        sda_t <= 1'b1;
        pend  <= 1'b0;
      end else if (sched) begin
        if (HOLD_CYC == 1) begin
          sda_t <= sched_val;
          pend  <= 1'b0;
        end else begin
          pend     <= 1'b1;
          pend_val <= sched_val;
          hold_cnt <= HOLD_LD;
        end
      end else if (pend) begin
        if (hold_cnt == 6'd1) begin
          sda_t <= pend_val;
          pend  <= 1'b0;
        end else begin
          hold_cnt <= hold_cnt - 6'd1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_i2c_target.sv
// ============================================================================
// Module  : tb_i2c_target
// Purpose : Directed bus-master bench for i2c_target with rx/read scoreboards.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_i2c_target;

  localparam int Q = 20;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       scl_drv = 1'b1;
  logic       sda_m = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       scl_i, sda_i, sda_t, rx_valid, tx_ack, busy;
  logic [7:0] rx_data;

  int total = 0;
  int bad = 0;
  int rx_cnt = 0;
  int txack_cnt = 0;
  int snap;
  bit sda_low_seen = 1'b0;
  logic [7:0] exp_rx[$];
  logic [7:0] exp_rd[$];
  logic       s;

  assign scl_i = scl_drv;
  assign sda_i = sda_m & sda_t;

  i2c_target #(.TARGET_ADDR(7'h50), .FILT_CYC(4), .HOLD_CYC(8)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .scl_i    (scl_i),
    .sda_i    (sda_i),
    .sda_t    (sda_t),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_ack   (tx_ack),
    .busy     (busy)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (sda_t === 1'b0) sda_low_seen = 1'b1;
    if (tx_ack === 1'b1) txack_cnt++;
    if (rx_valid === 1'b1) begin
      rx_cnt++;
      check("rx_expected", 32'(exp_rx.size() > 0), 1);
      if (exp_rx.size() > 0) check("rx_data", 32'(rx_data), 32'(exp_rx.pop_front()));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic bus_start;
    sda_m = 1'b0; cyc(Q);
    scl_drv = 1'b0; cyc(Q);
  endtask

  task automatic bus_rstart;
    sda_m = 1'b1; cyc(Q);
    scl_drv = 1'b1; cyc(Q);
    sda_m = 1'b0; cyc(Q);
    scl_drv = 1'b0; cyc(Q);
  endtask

  task automatic bus_stop;
    sda_m = 1'b0; cyc(Q);
    scl_drv = 1'b1; cyc(Q);
    sda_m = 1'b1; cyc(2 * Q);
  endtask

  // One SCL period; optional 2-cycle SCL glitch or reset pulse in the high phase.
  task automatic clock_bit(input logic b, input bit glitch, input bit do_rst, output logic smp);
    sda_m = b; cyc(Q);
    scl_drv = 1'b1; cyc(Q / 2);
    if (glitch) begin
      scl_drv = 1'b0; cyc(2);
      scl_drv = 1'b1;
    end
    if (do_rst) begin
      check("rst_pre_sda_t", 32'(sda_t), 0);
      RST = 1'b1; cyc(1);
      check("rst_sda_t", 32'(sda_t), 1);
      check("rst_busy", 32'(busy), 0);
      check("rst_tx_ack", 32'(tx_ack), 0);
      RST = 1'b0;
    end
    cyc(Q / 2);
    smp = sda_i;
    cyc(Q);
    scl_drv = 1'b0; cyc(Q);
  endtask

  task automatic write_byte(input logic [7:0] v, input bit exp_ack, input int glitch_bit,
                            input string tag);
    logic smp;
    for (int i = 7; i >= 0; i--) clock_bit(v[i], i == glitch_bit, 1'b0, smp);
    clock_bit(1'b1, 1'b0, 1'b0, smp);
    check({tag, "_ack"}, 32'(smp), exp_ack ? 0 : 1);
  endtask

  task automatic read_byte(input bit mack, input logic [7:0] next_tx, input string tag);
    logic [7:0] got;
    logic       smp;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b1, 1'b0, 1'b0, smp);
      got[i] = smp;
    end
    if (mack) begin
      tx_data = next_tx;
      exp_rd.push_back(next_tx);
    end
    clock_bit(mack ? 1'b0 : 1'b1, 1'b0, 1'b0, smp);
    check({tag, "_expected"}, 32'(exp_rd.size() > 0), 1);
    if (exp_rd.size() > 0) check(tag, 32'(got), 32'(exp_rd.pop_front()));
  endtask

  initial begin
    // Reset state
    cyc(5);
    check("reset_sda_t", 32'(sda_t), 1);
    check("reset_rx_data", 32'(rx_data), 0);
    check("reset_rx_valid", 32'(rx_valid), 0);
    check("reset_tx_ack", 32'(tx_ack), 0);
    check("reset_busy", 32'(busy), 0);
    RST = 1'b0;
    cyc(10);

    // Write 0x50/W, A5, 3C, STOP
    bus_start;
    write_byte(8'hA0, 1'b1, -1, "t1_addr");
    check("t1_busy", 32'(busy), 1);
    exp_rx.push_back(8'hA5);
    write_byte(8'hA5, 1'b1, -1, "t1_d0");
    exp_rx.push_back(8'h3C);
    write_byte(8'h3C, 1'b1, -1, "t1_d1");
    check("t1_busy_before_stop", 32'(busy), 1);
    bus_stop;
    check("t1_busy_after_stop", 32'(busy), 0);
    check("t1_rx_cnt", 32'(rx_cnt), 2);

    // Wrong address 0x51/W
    sda_low_seen = 1'b0;
    snap = rx_cnt;
    bus_start;
    write_byte(8'hA2, 1'b0, -1, "t2_addr");
    check("t2_busy", 32'(busy), 0);
    write_byte(8'h55, 1'b0, -1, "t2_d0");
    bus_stop;
    check("t2_sda_low_seen", 32'(sda_low_seen), 0);
    check("t2_rx_cnt", 32'(rx_cnt), 32'(snap));

    // Read 0x50/R: C3 with ACK, 5A with NACK
    tx_data = 8'hC3;
    exp_rd.push_back(8'hC3);
    snap = txack_cnt;
    bus_start;
    write_byte(8'hA1, 1'b1, -1, "t3_addr");
    check("t3_busy", 32'(busy), 1);
    read_byte(1'b1, 8'h5A, "t3_rd0");
    read_byte(1'b0, 8'h00, "t3_rd1");
    check("t3_sda_t_after_nack", 32'(sda_t), 1);
    check("t3_tx_ack_cnt", 32'(txack_cnt - snap), 2);
    bus_stop;
    check("t3_busy_after_stop", 32'(busy), 0);

    // Partial write, repeated START, then read
    snap = rx_cnt;
    bus_start;
    write_byte(8'hA0, 1'b1, -1, "t4_addr1");
    for (int i = 0; i < 4; i++) clock_bit(logic'(i[0]), 1'b0, 1'b0, s);
    tx_data = 8'h96;
    exp_rd.push_back(8'h96);
    bus_rstart;
    check("t4_busy_after_rstart", 32'(busy), 0);
    write_byte(8'hA1, 1'b1, -1, "t4_addr2");
    read_byte(1'b0, 8'h00, "t4_rd");
    bus_stop;
    check("t4_rx_cnt", 32'(rx_cnt), 32'(snap));

    // SCL glitch inside a data bit
    bus_start;
    write_byte(8'hA0, 1'b1, -1, "t5_addr");
    exp_rx.push_back(8'h6B);
    write_byte(8'h6B, 1'b1, 3, "t5_d0");
    bus_stop;
    check("t5_rx_cnt", 32'(rx_cnt), 32'(snap + 1));

    // Reset mid-read while the target drives SDA low
    tx_data = 8'h00;
    snap = txack_cnt;
    bus_start;
    write_byte(8'hA1, 1'b1, -1, "t6_addr");
    clock_bit(1'b1, 1'b0, 1'b0, s);
    check("t6_bit7", 32'(s), 0);
    clock_bit(1'b1, 1'b0, 1'b1, s);
    sda_low_seen = 1'b0;
    for (int i = 0; i < 6; i++) clock_bit(1'b1, 1'b0, 1'b0, s);
    clock_bit(1'b0, 1'b0, 1'b0, s);
    for (int i = 0; i < 8; i++) clock_bit(1'b1, 1'b0, 1'b0, s);
    check("t6_sda_low_seen", 32'(sda_low_seen), 0);
    check("t6_busy", 32'(busy), 0);
    check("t6_tx_ack_cnt", 32'(txack_cnt - snap), 1);
    bus_stop;
    snap = rx_cnt;
    bus_start;
    write_byte(8'hA0, 1'b1, -1, "t6_addr2");
    exp_rx.push_back(8'h77);
    write_byte(8'h77, 1'b1, -1, "t6_d0");
    bus_stop;
    check("t6_rx_cnt", 32'(rx_cnt), 32'(snap + 1));
    check("final_rx_queue_empty", 32'(exp_rx.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, summary not printed");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
